// File: rtl/dm_port_arbiter_if.sv
// Bundle of CPU, debug and data-memory signals around the dm port arbiter.
// master: the arbiter's view; slave: the surrounding pipeline/debug/memory view.
interface dm_port_arbiter_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
);
  // CPU MEM-stage side
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  // Debug/loader side
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  // Data-memory side
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a debug
// port. CPU has priority; a debug request that waits MAX_WAIT cycles behind
// CPU traffic is given a forced burst of up to DBG_BURST beats, during which
// the pipeline is stalled if the CPU wants the port.
module dm_port_arbiter #(
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned DBG_BURST = 4
) (
  input logic                clk,
  input logic                reset,
  dm_port_arbiter_if.master  bus
);

  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned BeatW = (DBG_BURST > 1) ? $clog2(DBG_BURST) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(DBG_BURST - 1);

  typedef enum logic [0:0] {StCpu, StDbg} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic          cpu_act;
  logic          cpu_own;
  logic          dbg_own;
  logic          dbg_gnt;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;

  // Ownership decision, starvation counters and burst tracking.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    cpu_own   = 1'b0;
    dbg_own   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_stall = 1'b0;
    // During reset nobody owns the port and no grant/stall is signalled.
    if (!reset) begin
      unique case (state_q)
        StCpu: begin
          if (cpu_act) begin
            cpu_own = 1'b1;
            if (bus.dbg_req) begin
              if (wait_q == WaitLast) begin
                state_d = StDbg;
                wait_d  = '0;
              end else begin
                wait_d = wait_q + WaitW'(1);
              end
            end else begin
              wait_d = '0;
            end
          end else if (bus.dbg_req) begin
            dbg_own = 1'b1;
            dbg_gnt = 1'b1;
            wait_d  = '0;
          end else begin
            wait_d = '0;
          end
        end
        StDbg: begin
          if (bus.dbg_req) begin
            dbg_own   = 1'b1;
            dbg_gnt   = 1'b1;
            cpu_stall = cpu_act;
            if (beat_q == BeatLast) begin
              state_d = StCpu;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + BeatW'(1);
            end
          end else begin
            // Burst abandoned early: hand the port straight back to the CPU.
            cpu_own = 1'b1;
            state_d = StCpu;
            beat_d  = '0;
          end
        end
        default: state_d = StCpu;
      endcase
    end
  end

  // Port mux; with no owner the address follows the CPU and strobes are low.
  always_comb begin
    mem_addr  = bus.cpu_addr;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = bus.cpu_wdata;
    if (dbg_own) begin
      mem_addr  = bus.dbg_addr;
      mem_rd    = ~bus.dbg_we;
      mem_wr    = bus.dbg_we;
      mem_wdata = bus.dbg_wdata;
    end else if (cpu_own) begin
      mem_rd = bus.cpu_rd;
      mem_wr = bus.cpu_wr;
    end
  end

  // Debug read return: capture memory data at the granted read beat.
  always_comb begin
    rvalid_d = dbg_gnt & ~bus.dbg_we;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rdata_d = bus.mem_rdata;
    end
  end

  // State and return registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StCpu;
      wait_q   <= '0;
      beat_q   <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = rvalid_q;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.mem_wdata  = mem_wdata;

endmodule
